arbitro_rr_n: RTL and testbench
===============================

Name: arbitro_rr_n

Overview:
- Parametrised N-requester round-robin arbiter; successor to the two-requester arbiter (req0/req1, gnt0/gnt1).
- Sits between N bus masters and one shared resource.
- Grants are registered and one-hot. An owner keeps its grant while its request stays high.
- Fairness comes from a rotating priority pointer.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- IDW, $clog2(N), width of gnt_id; derived, never overridden.
- MAX_HOLD, 8, maximum consecutive grant cycles before forced rotation; used only with ARBITRO_MAXHOLD_EN; must be ≥2.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  N  request vector; req[i] high = requester i wants the resource
- gnt  output  N  registered one-hot grant, all-zero when idle
- gnt_valid  output  1  registered; high when any gnt bit is high
- gnt_id  output  IDW  registered index of current owner; holds last owner when idle

Behaviour:
- Reset: sampled only on a rising clock edge while reset=1. Results: gnt=0, gnt_valid=0, gnt_id=0, pointer=0, state=IDLE. Reset during GRANT drops gnt at that edge; no partial handoff.
- States:
  - IDLE: no owner.
  - GRANT: owner = gnt_id.
- Pick function: first i with req[i]=1, searching pointer, pointer+1, … N-1, 0, … pointer-1 (mod N).
- IDLE, edge with req≠0: gnt ← onehot(pick), gnt_id ← pick, gnt_valid ← 1, pointer ← (pick+1) mod N, go to GRANT. Latency = 1 cycle from the first sampled request.
- IDLE, edge with req=0: stay in IDLE; outputs unchanged.
- GRANT, req[owner]=1: hold gnt unchanged (lock).
- GRANT, req[owner]=0, other requests pending: direct handoff at the same edge to pick(req) with the updated pointer. No idle cycle between owners; pointer advances.
- GRANT, req[owner]=0, no requests: gnt ← 0, gnt_valid ← 0, go to IDLE; gnt_id and pointer retained.
- Pointer wrap: N-1+1 → 0.
- Simultaneous requests: resolved only by the pointer, never by index. A previous owner re-requesting at its release edge loses to any other pending requester.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - gnt[gnt_id] == gnt_valid.
- Glitch rule: req bits that go high and low between edges have no effect.

Optional Feature:
- Macro: ARBITRO_MAXHOLD_EN.
- With the macro defined:
  - A hold counter (width $clog2(MAX_HOLD+1)) clears on every new grant and increments each GRANT cycle.
  - When count = MAX_HOLD-1 and any other req bit is high, the owner is forcibly rotated at the next edge, exactly as if it had dropped its request.
  - If the owner is the sole requester, it keeps the grant and the counter saturates.
- Without the macro: no counter; the owner holds indefinitely while its request stays high.

Decomposition:
- Package arbitro_pkg: state enum (ARB_IDLE, ARB_GRANT) and a function onehot(idx, N).
- Sub-module arbitro_rr_pick: combinational rotating priority encoder.
  - Inputs: req, pointer.
  - Outputs: pick index, any_req.
  - Reusable by the planned multi-channel arbiter.

Test Plan (N=4, MAX_HOLD=8):
- Reset: reset=1 for 2 cycles with req=4'b1111 → gnt=0, gnt_valid=0, gnt_id=0. Release reset → gnt=4'b0001 one cycle later.
- Single requester: req=4'b0100 for 5 cycles, then 0 → gnt=4'b0100 from cycle 1 through the release edge; then gnt=0 and gnt_id stays 2.
- Round robin: req=4'b1111 held, each owner drops its own bit for one cycle after 2 grant cycles → grant order 0,1,2,3,0 with no idle cycles between owners.
- Simultaneous release/request: owner 1 drops while req=4'b1001 and pointer=2 → next grant goes to 3, then 0.
- Lock vs. maxhold: req=4'b0011 held constant with owner 0.
  - Without the macro → gnt=4'b0001 forever.
  - With ARBITRO_MAXHOLD_EN → gnt switches to 4'b0010 after exactly 8 grant cycles, then back to 4'b0001 after 8 more.
- Reset mid-grant: assert reset while gnt=4'b1000 → gnt=0 at that edge; pointer=0 after release, so req=4'b1010 grants 1.

Source files
------------

// File: rtl/arbitro_pkg.sv
// ============================================================================
// Module   : arbitro_pkg
// Brief    : Shared types and helpers for the round-robin arbiter family.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arbitro_pkg;

    localparam int c_max_n = 16;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Out-of-range indices return all-zero so callers can slice to their own N.
    function automatic logic [c_max_n-1:0] onehot(input int unsigned idx,
                                                   input int unsigned n);
        logic [c_max_n-1:0] r_vec;
        r_vec = '0;
        if ((idx < n) && (idx < c_max_n)) begin
            r_vec = c_max_n'(1) << idx;
        end
        return r_vec;
    endfunction

endpackage

`default_nettype wire

// File: rtl/arbitro_rr_pick.sv
// ============================================================================
// Module   : arbitro_rr_pick
// Brief    : Combinational rotating priority encoder: first set req bit at or
//            after pointer, wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr_pick #(
    parameter  int N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] pointer,
    output logic [IDW-1:0] pick,
    output logic           any_req
);

    logic [N-1:0] w_upper_mask;
    logic [N-1:0] w_upper_req;
    logic [N-1:0] w_search;

    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    assign w_upper_mask = ~((N'(1) << pointer) - N'(1));
    assign w_upper_req  = req & w_upper_mask;
    assign w_search     = (|w_upper_req) ? w_upper_req : req;
    assign any_req      = |req;

    always_comb begin
        pick = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (w_search[j]) begin
                pick = IDW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/arbitro_rr_n.sv
// ============================================================================
// Module   : arbitro_rr_n
// Brief    : N-requester round-robin arbiter with registered one-hot grant and
//            request-held ownership. Define ARBITRO_MAXHOLD_EN to cap tenure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr_n
    import arbitro_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    localparam logic [IDW:0] c_n = (IDW + 1)'(N);

    arb_state_e     r_state_q, r_state_d;
    logic [N-1:0]   r_gnt_q,   r_gnt_d;
    logic           r_valid_q, r_valid_d;
    logic [IDW-1:0] r_id_q,    r_id_d;
    logic [IDW-1:0] r_ptr_q,   r_ptr_d;

    logic [N-1:0]   w_owner_oh;
    logic [N-1:0]   w_pick_req;
    logic [N-1:0]   w_pick_oh;
    logic [IDW-1:0] w_pick;
    logic [IDW:0]   w_pick_inc;
    logic [IDW-1:0] w_ptr_next;
    logic           w_any;
    logic           w_owner_req;
    logic           w_force;
    logic           w_new_grant;

    assign w_owner_oh  = N'(onehot(32'(r_id_q), N));
    assign w_owner_req = |(req & w_owner_oh);

    // The current owner never competes for its own handoff.
    assign w_pick_req  = (r_state_q == ARB_GRANT) ? (req & ~w_owner_oh) : req;

    arbitro_rr_pick #(
        .N       (N)
    ) u_pick (
        .req     (w_pick_req),
        .pointer (r_ptr_q),
        .pick    (w_pick),
        .any_req (w_any)
    );

    assign w_pick_oh  = N'(onehot(32'(w_pick), N));
    assign w_pick_inc = {1'b0, w_pick} + (IDW + 1)'(1);
    assign w_ptr_next = (w_pick_inc == c_n) ? '0 : w_pick_inc[IDW-1:0];

`ifdef ARBITRO_MAXHOLD_EN
    localparam int                  c_hold_w    = $clog2(MAX_HOLD + 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(MAX_HOLD - 1);

    logic [c_hold_w-1:0] r_hold_q, r_hold_d;

    // w_any here means some other requester is waiting.
    assign w_force = (r_hold_q == c_hold_last) && w_any;

    always_comb begin
        r_hold_d = r_hold_q;
        if (w_new_grant) begin
            r_hold_d = '0;
        end else if ((r_state_q == ARB_GRANT) && (r_hold_q != c_hold_last)) begin
            r_hold_d = r_hold_q + c_hold_w'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_q <= '0;
        end else begin
            r_hold_q <= r_hold_d;
        end
    end
`else
    // Tenure is unbounded when the hold limit is compiled out.
    assign w_force = (MAX_HOLD < 0);
`endif

    always_comb begin
        r_state_d   = r_state_q;
        r_gnt_d     = r_gnt_q;
        r_valid_d   = r_valid_q;
        r_id_d      = r_id_q;
        r_ptr_d     = r_ptr_q;
        w_new_grant = 1'b0;

        case (r_state_q)
            ARB_IDLE: begin
                if (w_any) begin
                    w_new_grant = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (!w_owner_req || w_force) begin
                    if (w_any) begin
                        w_new_grant = 1'b1;
                    end else begin
                        r_state_d = ARB_IDLE;
                        r_gnt_d   = '0;
                        r_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                r_state_d = ARB_IDLE;
            end
        endcase

        if (w_new_grant) begin
            r_state_d = ARB_GRANT;
            r_gnt_d   = w_pick_oh;
            r_valid_d = 1'b1;
            r_id_d    = w_pick;
            r_ptr_d   = w_ptr_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_q <= ARB_IDLE;
            r_gnt_q   <= '0;
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
            r_ptr_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_gnt_q   <= r_gnt_d;
            r_valid_q <= r_valid_d;
            r_id_q    <= r_id_d;
            r_ptr_q   <= r_ptr_d;
        end
    end

    assign gnt       = r_gnt_q;
    assign gnt_valid = r_valid_q;
    assign gnt_id    = r_id_q;

endmodule

`default_nettype wire

// File: tb/tb_arbitro_rr_n.sv
// ============================================================================
// Module   : tb_arbitro_rr_n
// Brief    : Scoreboard bench for arbitro_rr_n (N=4, MAX_HOLD=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arbitro_rr_n;

    localparam int N  = 4;
    localparam int MH = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;

    arbitro_rr_n #(
        .N         (N),
        .MAX_HOLD  (MH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] id;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: owner index (-1 when idle), last owner, next priority
    // start, and how many grant cycles the current owner has had.
    int m_owner = -1;
    int m_id    = 0;
    int m_ptr   = 0;
    int m_held  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic ref_grant(input int p);
        m_owner = p;
        m_id    = p;
        m_ptr   = (p + 1) % N;
        m_held  = 1;
    endtask

    task automatic model_step(input logic rst, input logic [3:0] r);
        int         p;
        logic [3:0] others;
        bit         release_owner;
        exp_t       e;
        if (rst) begin
            m_owner = -1;
            m_id    = 0;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            p = ref_pick(r, m_ptr);
            if (p >= 0) ref_grant(p);
        end else begin
            others          = r;
            others[m_owner] = 1'b0;
            release_owner   = !r[m_owner];
`ifdef ARBITRO_MAXHOLD_EN
            if (!release_owner && (others != 4'b0000) && (m_held >= MH)) release_owner = 1'b1;
`endif
            if (!release_owner) begin
                m_held++;
            end else begin
                p = ref_pick(others, m_ptr);
                if (p >= 0) ref_grant(p);
                else m_owner = -1;
            end
        end
        e.gnt   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.valid = (m_owner >= 0);
        e.id    = 2'(m_id);
        sb_q.push_back(e);
    endtask

    // Inputs change 2 time units after an edge; the DUT result of those
    // inputs is visible once this task returns.
    task automatic drive(input logic rst, input logic [3:0] r);
        reset = rst;
        req   = r;
        model_step(rst, r);
        @(posedge clock);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_gnt",      32'(gnt),          32'(e.gnt));
                chk("sb_valid",    32'(gnt_valid),    32'(e.valid));
                chk("sb_id",       32'(gnt_id),       32'(e.id));
                chk("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
                chk("inv_valid",   32'(gnt_valid),    32'(|gnt));
                chk("inv_id",      32'(gnt[gnt_id]),  32'(gnt_valid));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int         rr_exp[5];
        logic [3:0] exp_g;
        logic [3:0] r_rand;
        logic       rst_rand;

        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1111);
        chk("reset_gnt",   32'(gnt),       32'h0);
        chk("reset_valid", 32'(gnt_valid), 32'h0);
        chk("reset_id",    32'(gnt_id),    32'h0);
        drive(1'b0, 4'b1111);
        chk("release_gnt", 32'(gnt), 32'h1);
        drive(1'b0, 4'b0000);
        chk("drop_idle_gnt", 32'(gnt), 32'h0);

        // Single requester.
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b0100);
            chk("single_gnt", 32'(gnt), 32'h4);
        end
        drive(1'b0, 4'b0000);
        chk("single_idle_gnt", 32'(gnt),    32'h0);
        chk("single_idle_id",  32'(gnt_id), 32'h2);

        // Round robin with each owner dropping after two grant cycles.
        rr_exp = '{0, 1, 2, 3, 0};
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b1111);
        chk("rr_first", 32'(gnt_id), 32'(rr_exp[0]));
        for (int s = 0; s < 4; s++) begin
            drive(1'b0, 4'b1111);
            chk("rr_hold", 32'(gnt_id), 32'(rr_exp[s]));
            drive(1'b0, 4'b1111 & ~(4'b0001 << rr_exp[s]));
            chk("rr_order",   32'(gnt_id),    32'(rr_exp[s + 1]));
            chk("rr_no_idle", 32'(gnt_valid), 32'h1);
        end

        // Simultaneous release/request with pointer at 2.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0010);
        chk("sim_owner1", 32'(gnt_id), 32'h1);
        drive(1'b0, 4'b1001);
        chk("sim_next3", 32'(gnt_id), 32'h3);
        drive(1'b0, 4'b0001);
        chk("sim_next0", 32'(gnt_id), 32'h0);

        // Lock vs hold limit with two constant requesters.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0011);
        chk("lock_c1", 32'(gnt), 32'h1);
        for (int c = 2; c <= 17; c++) begin
            drive(1'b0, 4'b0011);
            exp_g = 4'b0001;
`ifdef ARBITRO_MAXHOLD_EN
            if (c >= 9 && c <= 16) exp_g = 4'b0010;
`endif
            chk("lock_gnt", 32'(gnt), 32'(exp_g));
        end

        // Reset in the middle of a grant.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b1000);
        chk("midrst_own3", 32'(gnt), 32'h8);
        drive(1'b1, 4'b1000);
        chk("midrst_drop", 32'(gnt), 32'h0);
        drive(1'b0, 4'b1010);
        chk("midrst_ptr0", 32'(gnt), 32'h2);

        // Randomised traffic, with requests tending to persist.
        r_rand = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            rst_rand = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 4) r_rand = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 9) < 3) r_rand = r_rand ^ (4'b0001 << $urandom_range(0, 3));
            drive(rst_rand, r_rand);
        end

        drive(1'b0, 4'b0000);
        repeat (2) @(posedge clock);
        #3;
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
